led_breather: RTL and testbench

- Downstream consumer of the blinker's divided-clock level output; shares the same 48 MHz oscillator clock domain and resetter output.
- Converts each rising edge of the slow `step_in` level into one brightness step.
- Runs a ramp-up / hold / ramp-down / hold breathing cycle and drives the LED pin through a registered PWM comparator.

---
 rtl/led_pkg.sv | 28 ++
 rtl/led_pwm_gen.sv | 50 +++++
 rtl/led_breather.sv | 138 +++++++++++++
 tb/tb_led_breather.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED breathing controller: state encodings,
// default PWM width and saturating brightness arithmetic.
package led_pkg;

    localparam int unsigned StateW     = 3;
    localparam int unsigned DefPwmBits = 8;

    typedef enum logic [StateW-1:0] {
        StIdle     = 3'd0,
        StRampUp   = 3'd1,
        StHoldHigh = 3'd2,
        StRampDown = 3'd3,
        StHoldLow  = 3'd4
    } led_state_e;

    // Sum is formed one bit wider than the operands so it can never wrap.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM generator with registered LED compare. Defining
// LED_BREATHER_GAMMA_EN inserts a one-stage squared (gamma) duty mapping.
module led_pwm_gen
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS = DefPwmBits
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty,
    output logic                led
);

    logic [PWM_BITS-1:0] r_cnt;
    logic [PWM_BITS-1:0] w_duty;
    logic                r_led;

`ifdef LED_BREATHER_GAMMA_EN
    logic [2*PWM_BITS-1:0] w_square;
    logic [PWM_BITS-1:0]   r_gamma;

    assign w_square = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_gamma <= '0;
        end else begin
            r_gamma <= PWM_BITS'(w_square >> PWM_BITS);
        end
    end

    assign w_duty = r_gamma;
`else
    assign w_duty = duty;
`endif

    // Counter runs regardless of the breathing enable.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt <= '0;
            r_led <= 1'b0;
        end else begin
            r_cnt <= r_cnt + PWM_BITS'(1);
            r_led <= (w_duty > r_cnt);
        end
    end

    assign led = r_led;

endmodule

// File: rtl/led_breather.sv
// LED breathing controller: ramp-up / hold / ramp-down / hold driven by rising
// edges of step_in. Optional gamma stage enabled by LED_BREATHER_GAMMA_EN.
module led_breather
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS   = DefPwmBits,
    parameter int unsigned STEP       = 16,
    parameter int unsigned HOLD_TICKS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                step_in,
    output logic                led,
    output logic [PWM_BITS-1:0] level,
    output logic [StateW-1:0]   state,
    output logic                cycle_done
);

    localparam int unsigned        MaxLvl   = (1 << PWM_BITS) - 1;
    localparam int unsigned        HoldW    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HoldW-1:0]   HoldLast = HoldW'(HOLD_TICKS - 1);

    if (HOLD_TICKS < 1) begin : g_hold_chk
        $error("HOLD_TICKS must be at least 1");
    end
    if (STEP < 1 || STEP > MaxLvl) begin : g_step_chk
        $error("STEP must lie in 1..2**PWM_BITS-1");
    end

    logic                r_step_q;
    led_state_e          r_state;
    logic [PWM_BITS-1:0] r_level;
    logic [HoldW-1:0]    r_hold;
    logic                r_cycle_done;

    led_state_e          w_state_d;
    logic [PWM_BITS-1:0] w_level_d;
    logic [HoldW-1:0]    w_hold_d;
    logic                w_done_d;
    logic                w_step_ev;
    logic [PWM_BITS-1:0] w_lvl_up;
    logic [PWM_BITS-1:0] w_lvl_dn;

    assign w_step_ev = step_in & ~r_step_q;
    assign w_lvl_up  = PWM_BITS'(sat_add(32'(r_level), STEP, MaxLvl));
    assign w_lvl_dn  = PWM_BITS'(sat_sub(32'(r_level), STEP));

    always_comb begin
        w_state_d = r_state;
        w_level_d = r_level;
        w_hold_d  = r_hold;
        w_done_d  = 1'b0;
        if (!enable) begin
            w_state_d = StIdle;
            w_level_d = '0;
            w_hold_d  = '0;
        end else begin
            case (r_state)
                StIdle: begin
                    w_state_d = StRampUp;
                    w_level_d = '0;
                    w_hold_d  = '0;
                end
                StRampUp: begin
                    if (w_step_ev) begin
                        w_level_d = w_lvl_up;
                        if (32'(w_lvl_up) == MaxLvl) begin
                            w_state_d = StHoldHigh;
                            w_hold_d  = '0;
                        end
                    end
                end
                StHoldHigh: begin
                    if (w_step_ev) begin
                        if (r_hold == HoldLast) w_state_d = StRampDown;
                        else                    w_hold_d  = r_hold + HoldW'(1);
                    end
                end
                StRampDown: begin
                    if (w_step_ev) begin
                        w_level_d = w_lvl_dn;
                        if (w_lvl_dn == '0) begin
                            w_state_d = StHoldLow;
                            w_hold_d  = '0;
                        end
                    end
                end
                StHoldLow: begin
                    if (w_step_ev) begin
                        if (r_hold == HoldLast) begin
                            w_state_d = StRampUp;
                            w_done_d  = 1'b1;
                        end else begin
                            w_hold_d = r_hold + HoldW'(1);
                        end
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_level_d = '0;
                    w_hold_d  = '0;
                end
            endcase
        end
    end

    // step_q resets high so a level already high at release is not an event.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_step_q     <= 1'b1;
            r_state      <= StIdle;
            r_level      <= '0;
            r_hold       <= '0;
            r_cycle_done <= 1'b0;
        end else begin
            r_step_q     <= step_in;
            r_state      <= w_state_d;
            r_level      <= w_level_d;
            r_hold       <= w_hold_d;
            r_cycle_done <= w_done_d;
        end
    end

    led_pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clock (clock),
        .reset (reset),
        .duty  (r_level),
        .led   (led)
    );

    assign level      = r_level;
    assign state      = r_state;
    assign cycle_done = r_cycle_done;

endmodule

// File: tb/tb_led_breather.sv
// Self-checking bench for led_breather (PWM_BITS=8, STEP=64, HOLD_TICKS=2),
// behavioural model plus directed literal checks; LED_BREATHER_GAMMA_EN aware.
module tb_led_breather;

    localparam int unsigned PB   = 8;
    localparam int          ST   = 64;
    localparam int          HT   = 2;
    localparam int          MAXL = 255;

`ifdef LED_BREATHER_GAMMA_EN
    localparam int LAG  = 3;
    localparam int E64  = 16;
    localparam int E128 = 64;
    localparam int E255 = 254;
`else
    localparam int LAG  = 2;
    localparam int E64  = 64;
    localparam int E128 = 128;
    localparam int E255 = 255;
`endif

    logic       clock   = 1'b0;
    logic       reset   = 1'b0;
    logic       enable  = 1'b0;
    logic       step_in = 1'b0;
    logic       led;
    logic [7:0] level;
    logic [2:0] state;
    logic       cycle_done;

    int total = 0;
    int bad   = 0;

    led_breather #(
        .PWM_BITS   (PB),
        .STEP       (ST),
        .HOLD_TICKS (HT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .step_in    (step_in),
        .led        (led),
        .level      (level),
        .state      (state),
        .cycle_done (cycle_done)
    );

    always #5 clock = ~clock;

    function automatic void chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Model: brightness, state and a PWM sweep derived from cycles since reset.
    int m_state = 0, m_level = 0, m_hold = 0, m_done = 0;
    int m_prev = 1, m_cnt = 0, m_led = 0, m_gam = 0;
    bit m_valid = 1'b0;

    always @(posedge clock) begin
        int ev;
        int duty;
        if (!reset) begin
            m_state = 0; m_level = 0; m_hold = 0; m_done = 0;
            m_prev = 1; m_cnt = 0; m_led = 0; m_gam = 0;
            m_valid = 1'b1;
        end else begin
`ifdef LED_BREATHER_GAMMA_EN
            duty  = m_gam;
            m_gam = (m_level * m_level) / 256;
`else
            duty = m_level;
`endif
            m_led  = (duty > m_cnt) ? 1 : 0;
            m_cnt  = (m_cnt + 1) % 256;
            ev     = (step_in && m_prev == 0) ? 1 : 0;
            m_prev = int'(step_in);
            m_done = 0;
            if (!enable) begin
                m_state = 0; m_level = 0; m_hold = 0;
            end else begin
                case (m_state)
                    0: begin m_state = 1; m_level = 0; m_hold = 0; end
                    1: if (ev == 1) begin
                        m_level = (m_level + ST > MAXL) ? MAXL : m_level + ST;
                        if (m_level == MAXL) begin m_state = 2; m_hold = 0; end
                    end
                    2: if (ev == 1) begin
                        if (m_hold == HT - 1) m_state = 3; else m_hold++;
                    end
                    3: if (ev == 1) begin
                        m_level = (m_level < ST) ? 0 : m_level - ST;
                        if (m_level == 0) begin m_state = 4; m_hold = 0; end
                    end
                    4: if (ev == 1) begin
                        if (m_hold == HT - 1) begin m_state = 1; m_done = 1; end
                        else m_hold++;
                    end
                    default: begin m_state = 0; m_level = 0; m_hold = 0; end
                endcase
            end
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            chk("model_led", int'(led), m_led);
            chk("model_level", int'(level), m_level);
            chk("model_state", int'(state), m_state);
            chk("model_done", int'(cycle_done), m_done);
        end
    end

    task automatic step_edge();
        @(negedge clock) step_in = 1'b0;
        @(negedge clock) step_in = 1'b1;
        @(negedge clock);
    endtask

    task automatic measure(string nm, int exp);
        int hi;
        hi = 0;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            hi += int'(led);
        end
        chk(nm, hi, exp);
    endtask

    initial begin
        int up [4];
        int dn [4];
        up = '{64, 128, 192, 255};
        dn = '{191, 127, 63, 0};

        reset = 1'b0; enable = 1'b1; step_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            step_in = ~step_in;
        end
        chk("rst_level", int'(level), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_led", int'(led), 0);
        chk("rst_done", int'(cycle_done), 0);

        // Release with step_in already high: no event expected.
        reset = 1'b1; step_in = 1'b1;
        @(negedge clock);
        chk("release_state", int'(state), 1);
        chk("release_level", int'(level), 0);

        for (int i = 0; i < 4; i++) begin
            step_edge();
            chk("ramp_up_level", int'(level), up[i]);
        end
        chk("hold_high_state", int'(state), 2);
        step_edge();
        chk("hold_high_mid", int'(state), 2);
        step_edge();
        chk("ramp_down_state", int'(state), 3);
        for (int i = 0; i < 4; i++) begin
            step_edge();
            chk("ramp_down_level", int'(level), dn[i]);
        end
        chk("hold_low_state", int'(state), 4);
        step_edge();
        chk("hold_low_mid", int'(state), 4);
        step_edge();
        chk("cycle_state", int'(state), 1);
        chk("cycle_done_hi", int'(cycle_done), 1);
        @(negedge clock);
        chk("cycle_done_lo", int'(cycle_done), 0);

        step_edge();
        chk("pwm64_level", int'(level), 64);
        measure("pwm64_high", E64);
        step_edge();
        measure("pwm128_high", E128);
        step_edge();
        step_edge();
        chk("pwm255_state", int'(state), 2);
        measure("pwm255_high", E255);
        repeat (6) step_edge();
        chk("pwm0_state", int'(state), 4);
        measure("pwm0_high", 0);
        repeat (2) step_edge();
        step_edge();
        step_edge();
        chk("abort_pre_level", int'(level), 128);

        // Enable drop coincident with a step event.
        @(negedge clock) step_in = 1'b0;
        @(negedge clock) begin step_in = 1'b1; enable = 1'b0; end
        @(negedge clock);
        chk("abort_en_state", int'(state), 0);
        chk("abort_en_level", int'(level), 0);
        repeat (LAG - 1) @(negedge clock);
        chk("abort_en_led", int'(led), 0);

        enable = 1'b1;
        @(negedge clock);
        chk("reenable_state", int'(state), 1);
        step_edge();
        step_edge();
        chk("abort2_pre_level", int'(level), 128);

        // Reset coincident with a step event.
        @(negedge clock) step_in = 1'b0;
        @(negedge clock) begin step_in = 1'b1; reset = 1'b0; end
        @(negedge clock) reset = 1'b1;
        chk("abort_rst_state", int'(state), 0);
        chk("abort_rst_level", int'(level), 0);
        chk("abort_rst_led", int'(led), 0);
        @(negedge clock);
        chk("abort_rst_restart", int'(state), 1);
        chk("abort_rst_led2", int'(led), 0);
        chk("abort_rst_nolevel", int'(level), 0);

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
